// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key sequencer.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
        logic       rpt;
    } key_evt_t;

    // True for bytes that only modify the following scan code.
    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_BRK) || (b == PS2_EXT);
    endfunction

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// FIFO-side handshake between the ps2_keyboard receiver and the key sequencer.
// master: receiver FIFO; slave: sequencer.
interface ps2_key_sequencer_if;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       kb_overflow;
    logic       nextdata_n;

    modport master (output kb_data, output kb_ready, output kb_overflow, input nextdata_n);
    modport slave  (input kb_data, input kb_ready, input kb_overflow, output nextdata_n);
endinterface

// File: rtl/ps2_key_sequencer.sv
// Drains the PS/2 receiver FIFO one byte per three cycles and turns set-2
// scan-code sequences into single-cycle key events, with held-key tracking,
// press counting and sticky overflow.
//
// state | meaning
// IDLE  | waiting for kb_ready; the head byte is captured and decoded on leaving
// POP   | nextdata_n low for one cycle to advance the FIFO
// WAIT  | nextdata_n high so ready/data resettle before the next capture
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ps2_key_sequencer_if.slave   kb,
    input  logic                 i_ovf_clr,
    output logic                 o_evt_valid,
    output logic [7:0]           o_evt_code,
    output logic                 o_evt_break,
    output logic                 o_evt_ext,
    output logic                 o_evt_repeat,
    output logic                 o_held,
    output logic [7:0]           o_held_code,
    output logic                 o_held_ext,
    output logic [CNT_W-1:0]     o_press_cnt,
    output logic                 o_ovf_sticky
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_capture;
    logic               w_nextdata_n;

    logic               r_brk_p;
    logic               r_ext_p;
    logic [TMO_W-1:0]   r_tmo;
    logic               w_tmo_done;

    logic               r_evt_valid;
    key_evt_t           r_evt;
    key_evt_t           w_evt;
    logic               w_is_key;
    logic               w_held_match;

    logic               r_held;
    logic [7:0]         r_held_code;
    logic               r_held_ext;
    logic [CNT_W-1:0]   r_press_cnt;
    logic               r_ovf;

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next state and FIFO pop strobe
    always_comb begin
        w_state_nxt  = r_state;
        w_nextdata_n = 1'b1;
        w_capture    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (kb.kb_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = POP;
                end
            end
            POP: begin
                w_nextdata_n = 1'b0;
                w_state_nxt  = WAIT;
            end
            WAIT:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign kb.nextdata_n = w_nextdata_n;

    // Decode the FIFO head byte against the pending prefixes and the held key
    always_comb begin
        w_is_key     = !is_prefix(kb.kb_data);
        w_held_match = r_held && ({r_held_ext, r_held_code} == {r_ext_p, kb.kb_data});
        w_evt.code   = kb.kb_data;
        w_evt.brk    = r_brk_p;
        w_evt.ext    = r_ext_p;
        w_evt.rpt    = !r_brk_p && w_held_match;
    end

    assign w_tmo_done = (r_tmo == TMO_LAST);

    // Prefix flags and the prefix timeout; a capture always wins over a timeout
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_brk_p <= 1'b0;
            r_ext_p <= 1'b0;
            r_tmo   <= '0;
        end else if (w_capture) begin
            r_tmo <= '0;
            if (kb.kb_data == PS2_EXT) begin
                r_ext_p <= 1'b1;
            end else if (kb.kb_data == PS2_BRK) begin
                r_brk_p <= 1'b1;
            end else begin
                r_brk_p <= 1'b0;
                r_ext_p <= 1'b0;
            end
        end else if (r_brk_p || r_ext_p) begin
            if (w_tmo_done) begin
                r_brk_p <= 1'b0;
                r_ext_p <= 1'b0;
                r_tmo   <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    // Event register: fields hold between events, only the valid bit pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_evt_valid <= 1'b0;
            r_evt       <= '0;
        end else begin
            r_evt_valid <= w_capture && w_is_key;
            if (w_capture && w_is_key) r_evt <= w_evt;
        end
    end

    // Held key and distinct-press counter; repeats leave both untouched
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_held      <= 1'b0;
            r_held_code <= '0;
            r_held_ext  <= 1'b0;
            r_press_cnt <= '0;
        end else if (w_capture && w_is_key) begin
            if (!r_brk_p) begin
                if (!w_held_match) begin
                    r_press_cnt <= r_press_cnt + 1'b1;
                    r_held      <= 1'b1;
                    r_held_code <= kb.kb_data;
                    r_held_ext  <= r_ext_p;
                end
            end else if (w_held_match) begin
                r_held <= 1'b0;
            end
        end
    end

    // Sticky overflow; a new overflow beats a simultaneous clear
    always_ff @(posedge i_clk) begin
        if (i_rst)                r_ovf <= 1'b0;
        else if (kb.kb_overflow)  r_ovf <= 1'b1;
        else if (i_ovf_clr)       r_ovf <= 1'b0;
    end

    assign o_evt_valid  = r_evt_valid;
    assign o_evt_code   = r_evt.code;
    assign o_evt_break  = r_evt.brk;
    assign o_evt_ext    = r_evt.ext;
    assign o_evt_repeat = r_evt.rpt;
    assign o_held       = r_held;
    assign o_held_code  = r_held_code;
    assign o_held_ext   = r_held_ext;
    assign o_press_cnt  = r_press_cnt;
    assign o_ovf_sticky = r_ovf;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: a behavioural FIFO feeds scan-code bytes,
// events are logged and compared against hand-computed expectations.
module tb_ps2_key_sequencer;
    import ps2_pkg::*;

    localparam int CNT_W = 8;
    localparam int TMO   = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ovf_clr = 1'b0;
    logic             evt_valid, evt_break, evt_ext, evt_repeat, held, held_ext, ovf_sticky;
    logic [7:0]       evt_code, held_code;
    logic [CNT_W-1:0] press_cnt;

    ps2_key_sequencer_if kb ();

    ps2_key_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .kb           (kb),
        .i_ovf_clr    (ovf_clr),
        .o_evt_valid  (evt_valid),
        .o_evt_code   (evt_code),
        .o_evt_break  (evt_break),
        .o_evt_ext    (evt_ext),
        .o_evt_repeat (evt_repeat),
        .o_held       (held),
        .o_held_code  (held_code),
        .o_held_ext   (held_ext),
        .o_press_cnt  (press_cnt),
        .o_ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] fifo [$];
    key_evt_t   log_q [$];
    int         cyc = 0;
    int         n_low = 0;
    int         n_dbl = 0;
    int         first_low = -1;
    int         first_valid = -1;
    logic       prev_valid = 1'b0;

    typedef struct {
        int         n;
        logic [7:0] b [6];
        int         nevt;
        logic [7:0] code [5];
        logic [4:0] brk;
        logic [4:0] ext;
        logic [4:0] rpt;
        int         press;
        logic       hld;
        logic [7:0] hcode;
        logic       hext;
    } vec_t;

    vec_t tv [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fifo_drive();
        kb.kb_ready = (fifo.size() > 0);
        kb.kb_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        fifo_drive();
    endtask

    // One clock: FIFO pops on an edge seen with nextdata_n low and ready high
    task automatic step();
        logic pop_now;
        pop_now = !kb.nextdata_n && kb.kb_ready;
        if (!kb.nextdata_n) begin
            n_low++;
            if (first_low < 0) first_low = cyc;
        end
        @(posedge clk);
        if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
        #1;
        fifo_drive();
        cyc++;
        if (evt_valid) begin
            log_q.push_back(key_evt_t'({evt_code, evt_break, evt_ext, evt_repeat}));
            if (first_valid < 0) first_valid = cyc;
            if (prev_valid) n_dbl++;
        end
        prev_valid = evt_valid;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (fifo.size() > 0 && k < 2000) begin
            step();
            k++;
        end
        if (fifo.size() > 0) check({name, "_drain_timeout"}, fifo.size(), 0);
        steps(4);
    endtask

    task automatic clear_log();
        log_q.delete();
        n_low = 0;
        n_dbl = 0;
        first_low = -1;
        first_valid = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        step();
        clear_log();
    endtask

    initial begin
        kb.kb_overflow = 1'b0;
        fifo_drive();

        tv[0].n = 1; tv[0].b[0] = 8'h15;
        tv[0].nevt = 1; tv[0].code[0] = 8'h15;
        tv[0].brk = 5'b00000; tv[0].ext = 5'b00000; tv[0].rpt = 5'b00000;
        tv[0].press = 1; tv[0].hld = 1'b1; tv[0].hcode = 8'h15; tv[0].hext = 1'b0;

        tv[1].n = 5;
        tv[1].b[0] = 8'h15; tv[1].b[1] = 8'h15; tv[1].b[2] = 8'h15; tv[1].b[3] = 8'hF0; tv[1].b[4] = 8'h15;
        tv[1].nevt = 4;
        tv[1].code[0] = 8'h15; tv[1].code[1] = 8'h15; tv[1].code[2] = 8'h15; tv[1].code[3] = 8'h15;
        tv[1].brk = 5'b01000; tv[1].ext = 5'b00000; tv[1].rpt = 5'b00110;
        tv[1].press = 1; tv[1].hld = 1'b0; tv[1].hcode = 8'h15; tv[1].hext = 1'b0;

        tv[2].n = 5;
        tv[2].b[0] = 8'hE0; tv[2].b[1] = 8'h75; tv[2].b[2] = 8'hE0; tv[2].b[3] = 8'hF0; tv[2].b[4] = 8'h75;
        tv[2].nevt = 2; tv[2].code[0] = 8'h75; tv[2].code[1] = 8'h75;
        tv[2].brk = 5'b00010; tv[2].ext = 5'b00011; tv[2].rpt = 5'b00000;
        tv[2].press = 1; tv[2].hld = 1'b0; tv[2].hcode = 8'h75; tv[2].hext = 1'b1;

        tv[3].n = 5;
        tv[3].b[0] = 8'h1C; tv[3].b[1] = 8'h32; tv[3].b[2] = 8'hF0; tv[3].b[3] = 8'h1C; tv[3].b[4] = 8'h32;
        tv[3].nevt = 4;
        tv[3].code[0] = 8'h1C; tv[3].code[1] = 8'h32; tv[3].code[2] = 8'h1C; tv[3].code[3] = 8'h32;
        tv[3].brk = 5'b00100; tv[3].ext = 5'b00000; tv[3].rpt = 5'b01000;
        tv[3].press = 2; tv[3].hld = 1'b1; tv[3].hcode = 8'h32; tv[3].hext = 1'b0;

        tv[4].n = 3; tv[4].b[0] = 8'hE0; tv[4].b[1] = 8'h6B; tv[4].b[2] = 8'h6B;
        tv[4].nevt = 2; tv[4].code[0] = 8'h6B; tv[4].code[1] = 8'h6B;
        tv[4].brk = 5'b00000; tv[4].ext = 5'b00001; tv[4].rpt = 5'b00000;
        tv[4].press = 2; tv[4].hld = 1'b1; tv[4].hcode = 8'h6B; tv[4].hext = 1'b0;

        // Reset state
        do_reset();
        check("rst_nextdata_n", kb.nextdata_n, 1);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_fields", {evt_code, evt_break, evt_ext, evt_repeat}, 0);
        check("rst_held", {held, held_code, held_ext}, 0);
        check("rst_press_cnt", press_cnt, 0);
        check("rst_ovf", ovf_sticky, 0);

        // Table-driven byte sequences
        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int i = 0; i < tv[v].n; i++) push(tv[v].b[i]);
            drain($sformatf("v%0d", v));
            check($sformatf("v%0d_nevt", v), log_q.size(), tv[v].nevt);
            for (int e = 0; e < tv[v].nevt && e < log_q.size(); e++) begin
                check($sformatf("v%0d_e%0d_code", v, e), log_q[e].code, tv[v].code[e]);
                check($sformatf("v%0d_e%0d_brk", v, e), log_q[e].brk, tv[v].brk[e]);
                check($sformatf("v%0d_e%0d_ext", v, e), log_q[e].ext, tv[v].ext[e]);
                check($sformatf("v%0d_e%0d_rpt", v, e), log_q[e].rpt, tv[v].rpt[e]);
            end
            check($sformatf("v%0d_pop_cycles", v), n_low, tv[v].n);
            check($sformatf("v%0d_valid_pulse", v), n_dbl, 0);
            check($sformatf("v%0d_press_cnt", v), press_cnt, tv[v].press);
            check($sformatf("v%0d_held", v), held, tv[v].hld);
            if (tv[v].hld) begin
                check($sformatf("v%0d_held_code", v), held_code, tv[v].hcode);
                check($sformatf("v%0d_held_ext", v), held_ext, tv[v].hext);
            end
            check($sformatf("v%0d_code_hold", v), evt_code, tv[v].code[tv[v].nevt-1]);
            if (v == 0) check("v0_evt_latency", first_valid, first_low);
        end

        // Prefix dropped after the idle timeout
        do_reset();
        push(8'hF0);
        drain("tmo");
        steps(TMO + 2);
        push(8'h1C);
        drain("tmo2");
        check("tmo_nevt", log_q.size(), 1);
        if (log_q.size() > 0) begin
            check("tmo_code", log_q[0].code, 8'h1C);
            check("tmo_brk", log_q[0].brk, 0);
        end

        // Prefix kept when the next byte arrives inside the timeout
        do_reset();
        push(8'hF0);
        drain("notmo");
        push(8'h1C);
        drain("notmo2");
        check("notmo_nevt", log_q.size(), 1);
        if (log_q.size() > 0) check("notmo_brk", log_q[0].brk, 1);

        // Press counter wrap and non-matching break
        do_reset();
        for (int i = 0; i < 255; i++) push((i % 2 == 0) ? 8'h1C : 8'h32);
        drain("wrap");
        check("wrap_allones", press_cnt, 8'hFF);
        push(8'h4D);
        drain("wrap2");
        check("wrap_zero", press_cnt, 8'h00);
        check("wrap_held_code", held_code, 8'h4D);
        push(8'hF0);
        push(8'h1C);
        drain("nmbrk");
        check("nmbrk_held", held, 1);
        check("nmbrk_held_code", held_code, 8'h4D);
        check("nmbrk_evt", {evt_code, evt_break, evt_repeat}, {8'h1C, 1'b1, 1'b0});
        check("nmbrk_press_cnt", press_cnt, 8'h00);

        // Sticky overflow: set beats clear, clear alone clears
        do_reset();
        kb.kb_overflow = 1'b1;
        ovf_clr = 1'b1;
        step();
        check("ovf_set_wins", ovf_sticky, 1);
        kb.kb_overflow = 1'b0;
        ovf_clr = 1'b0;
        step();
        check("ovf_hold", ovf_sticky, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr", ovf_sticky, 0);

        // Reset asserted during POP
        kb.kb_overflow = 1'b1;
        step();
        kb.kb_overflow = 1'b0;
        push(8'h15);
        begin
            int k;
            k = 0;
            while (kb.nextdata_n !== 1'b0 && k < 10) begin
                step();
                k++;
            end
            check("pop_reached", kb.nextdata_n, 0);
        end
        check("pop_evt_valid", evt_valid, 1);
        rst = 1'b1;
        step();
        check("rstpop_nextdata_n", kb.nextdata_n, 1);
        check("rstpop_evt", {evt_valid, evt_code, evt_break, evt_ext, evt_repeat}, 0);
        check("rstpop_held", {held, held_code, held_ext}, 0);
        check("rstpop_press_cnt", press_cnt, 0);
        check("rstpop_ovf", ovf_sticky, 0);
        rst = 1'b0;
        steps(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
